// File: rtl/apb_manager_n.sv
// APB manager: CPU transfer/ready bus to NUM_SLV completers, base/window decode.
// Build option APB_PSLVERR_EN adds a per-completer PSLVERR input.
module apb_manager_n #(
    parameter int                 NUM_SLV   = 8,
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h1000_0000,
    parameter int                 WIN_LOG2  = 12,
    parameter int                 TIMEOUT   = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        transfer,
    input  logic                        write,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        ready,
    output logic                        error,
    output logic [ADDR_W-1:0]           PADDR,
    output logic                        PWRITE,
    output logic                        PENABLE,
    output logic [DATA_W-1:0]           PWDATA,
    output logic [NUM_SLV-1:0]          PSEL,
`ifdef APB_PSLVERR_EN
    input  logic [NUM_SLV-1:0]          PSLVERR,
`endif
    input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]          PREADY
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-1:0]   win;
    logic                hit;
    logic [NUM_SLV-1:0]  sel_dec;
    logic                pready_sel;
    logic                slverr_sel;
    logic                tmo;
    logic [DATA_W-1:0]   prd_sel;

    assign off     = addr - BASE_ADDR;
    assign win     = off >> WIN_LOG2;
    assign hit     = (addr >= BASE_ADDR) && (win < ADDR_W'(NUM_SLV));
    assign sel_dec = NUM_SLV'(1) << win;

    // PSEL is one-hot on the latched index, so masking replaces indexing
    assign pready_sel = |(PREADY & PSEL);
    assign tmo        = (cnt == CW'(TIMEOUT - 1));

`ifdef APB_PSLVERR_EN
    assign slverr_sel = |(PSLVERR & PSEL);
`else
    assign slverr_sel = 1'b0;
`endif

    always_comb begin
        prd_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (PSEL[i]) prd_sel = prd_sel | PRDATA[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        ready = 1'b0;
        error = 1'b0;
        rdata = '0;
        unique case (state)
            ACCESS: begin
                if (pready_sel) begin
                    ready = 1'b1;
                    error = slverr_sel;
                    if (!PWRITE) rdata = prd_sel;
                end else if (tmo) begin
                    ready = 1'b1;
                    error = 1'b1;
                end
            end
            ERR: begin
                ready = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            PENABLE <= 1'b0;
            PSEL    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (transfer) begin
                        PADDR  <= addr;
                        PWRITE <= write;
                        PWDATA <= wdata;
                        if (hit) begin
                            PSEL  <= sel_dec;
                            state <= SETUP;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_sel || tmo) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ERR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_manager_n.md
Name: apb_manager_n

Overview:
Parametrised APB manager (successor to the fixed 4-slot APB manager) bridging the CPU bus (transfer/ready) to NUM_SLV APB completers.
- Address decode uses a base/window scheme instead of fixed slots.
- Adds a decode-error response and a PREADY timeout, so a bad address or a hung peripheral never stalls the core.
- Sits between CPU_RV32I and RAM/GPO/GPI/UART-class peripherals in the MCU top.

Parameters:
NUM_SLV, 8, number of APB completers (1..16)
DATA_W, 32, data width
ADDR_W, 32, address width
BASE_ADDR, 32'h1000_0000, start of completer 0 window
WIN_LOG2, 12, log2 window size per completer (4 KB); windows contiguous
TIMEOUT, 16, ACCESS cycles without PREADY before forced error completion (>=2)

Ports:
PCLK  in  1  clock, single clock domain
PRESET  in  1  reset, synchronous, active-high
transfer  in  1  CPU request strobe, sampled only in IDLE
write  in  1  1=write, 0=read
addr  in  ADDR_W  byte address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid while ready=1
ready  out  1  one-cycle completion pulse
error  out  1  qualifies ready: decode error or timeout (or PSLVERR when enabled)
PADDR  out  ADDR_W  latched full address
PWRITE  out  1  latched direction
PENABLE  out  1  APB enable
PWDATA  out  DATA_W  latched write data
PSEL  out  NUM_SLV  one-hot select
PRDATA  in  NUM_SLV*DATA_W  flattened; slice i = completer i
PREADY  in  NUM_SLV  per-completer ready

Behaviour:
- Reset (PRESET=1 at PCLK edge, any state, including mid-transfer):
  - State goes to IDLE; timeout counter cleared.
  - PADDR, PWDATA, rdata = 0; PWRITE, PENABLE, ready, error = 0; PSEL = 0.
  - An in-flight transfer is dropped with no completion.
- Decode:
  - off = addr - BASE_ADDR; idx = off >> WIN_LOG2.
  - Hit iff addr >= BASE_ADDR and idx < NUM_SLV.
- States: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - PSEL=0, PENABLE=0, ready=0.
  - On transfer=1: latch addr/write/wdata into PADDR/PWRITE/PWDATA and latch idx.
  - Hit -> SETUP. Miss -> ERR.
- SETUP: PSEL[idx]=1, PENABLE=0; next cycle -> ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1; counter increments each cycle.
  - If PREADY[idx]=1: combinationally ready=1, error=0, rdata=PRDATA slice idx (0 on writes); next -> IDLE.
  - Else if counter==TIMEOUT-1: ready=1, error=1, rdata=0; next -> IDLE. PSEL/PENABLE drop next cycle.
  - PREADY and timeout in the same cycle: PREADY wins, no error.
- ERR: one cycle; ready=1, error=1, rdata=0, PSEL=0; -> IDLE.
- Other rules:
  - PREADY of unselected completers is ignored.
  - PADDR/PWRITE/PWDATA remain stable from SETUP through ACCESS completion and hold last value in IDLE.
  - transfer asserted outside IDLE is ignored. The CPU holds its request until ready; back-to-back transfers incur one IDLE cycle.
- Latency:
  - Zero-wait completer: ready 2 cycles after the transfer-sampling edge (SETUP, ACCESS).
  - Decode miss: ready 1 cycle after.
  - Timeout: ready TIMEOUT+1 cycles after.

Optional Feature:
Macro APB_PSLVERR_EN.
- Defined: adds input PSLVERR [NUM_SLV]. On PREADY completion, error = PSLVERR[idx]; rdata is still driven from PRDATA.
- Undefined: port absent; PREADY completion always has error=0.

Test Plan:
- Zero-wait write: transfer, write=1, addr=0x1000_1004, wdata=0xDEAD_BEEF, PREADY[1]=1 -> PSEL=0b0000_0010, PENABLE=0 then 1, PADDR=0x1000_1004, PWDATA=0xDEAD_BEEF, ready 2 cycles later, error=0.
- Wait-state read: addr=0x1000_7010, PREADY[7] low 3 ACCESS cycles then high with PRDATA slice7=0x1234_5678 -> ready on 4th ACCESS cycle, rdata=0x1234_5678, PADDR stable throughout.
- Decode miss: addr=0x1000_8000 and addr=0x0FFF_FFFC -> PSEL stays 0, ready=1 with error=1 and rdata=0 one cycle later.
- Timeout: addr=0x1000_2000, PREADY[2] held 0, TIMEOUT=16 -> ready=1, error=1 on 16th ACCESS cycle; PSEL=0 next cycle. Also PREADY rising on that same cycle -> error=0.
- Reset mid-ACCESS: PRESET=1 during wait -> next edge all outputs 0, state IDLE; a new transfer to 0x1000_0000 then completes normally.
- APB_PSLVERR_EN: PREADY[3]=1 with PSLVERR[3]=1 -> ready=1, error=1; PSLVERR[4]=1 while idx=3 -> error=0.
